// File: rtl/noc_pkg.sv
// Shared NoC types and constants for the router input stage.
package noc_pkg;

    localparam int NOC_DATA_W = 64;

    typedef logic [NOC_DATA_W-1:0] flit_t;

    // VC polarity names used when a port runs two virtual channels.
    localparam int VC_EVEN = 0;
    localparam int VC_ODD  = 1;

    function automatic int vc_width(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

endpackage

// File: rtl/router_vc_fifo.sv
// Single virtual-channel circular FIFO; emptiness is tracked by count alone.
module router_vc_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/router_input_vc_buffer.sv
// Router input port: per-VC FIFOs with registered ready, blocked stall and sticky drop flag.
module router_input_vc_buffer
    import noc_pkg::*;
#(
    parameter int DATA_W = NOC_DATA_W,
    parameter int NUM_VC = 2,
    parameter int DEPTH  = 4,
    localparam int VC_W  = vc_width(NUM_VC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send,
    input  logic [VC_W-1:0]   in_vc,
    input  logic [DATA_W-1:0] data_in,
    output logic [NUM_VC-1:0] ready,
    input  logic              blocked,
    input  logic [VC_W-1:0]   out_vc,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              drop_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_VC-1:0][DATA_W-1:0] head;
    logic [NUM_VC-1:0][CNT_W-1:0]  count;
    logic [NUM_VC-1:0][CNT_W-1:0]  count_next;
    logic [NUM_VC-1:0]             full;
    logic [NUM_VC-1:0]             empty;
    logic [NUM_VC-1:0]             push_vec;
    logic [NUM_VC-1:0]             pop_vec;
    logic [NUM_VC-1:0]             ready_next;
    logic [DATA_W-1:0]             head_sel;
    logic                          in_ready;
    logic                          drop;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        router_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push    (push_vec[v]),
            .pop     (pop_vec[v]),
            .data_in (data_in),
            .head    (head[v]),
            .count   (count[v]),
            .full    (full[v]),
            .empty   (empty[v])
        );
    end

    // Pop looks at pre-edge occupancy, so a flit pushed this edge cannot bypass.
    always_comb begin
        in_ready   = 1'b0;
        head_sel   = '0;
        push_vec   = '0;
        pop_vec    = '0;
        count_next = count;
        ready_next = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (in_vc == VC_W'(v))
                in_ready = ready[v];
            if (out_vc == VC_W'(v))
                head_sel = head[v];
            push_vec[v]   = send && (in_vc == VC_W'(v)) && ready[v] && !full[v];
            pop_vec[v]    = !blocked && (out_vc == VC_W'(v)) && !empty[v];
            count_next[v] = count[v] + CNT_W'(push_vec[v]) - CNT_W'(pop_vec[v]);
            ready_next[v] = !blocked && (count_next[v] < CNT_W'(DEPTH));
        end
    end

    assign drop = send && !in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            ready     <= '1;
            out_valid <= 1'b0;
            data_out  <= '0;
            drop_err  <= 1'b0;
        end else begin
            ready     <= ready_next;
            out_valid <= |pop_vec;
            data_out  <= (|pop_vec) ? head_sel : '0;
            if (drop)
                drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_router_input_vc_buffer.sv
// Bench for router_input_vc_buffer: vector table plus queue-model scoreboard.
module tb_router_input_vc_buffer;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        send = 1'b0;
    logic [0:0]  in_vc = '0;
    logic [63:0] data_in = '0;
    logic [1:0]  ready;
    logic        blocked = 1'b0;
    logic [0:0]  out_vc = '0;
    logic        out_valid;
    logic [63:0] data_out;
    logic        drop_err;

    int errors = 0;
    int checks = 0;

    // Behavioural model: one queue per VC, expected outputs queued at drive time.
    logic [63:0] mq0[$];
    logic [63:0] mq1[$];
    logic [63:0] exp_q[$];
    logic [1:0]  rdy_m;
    logic        drop_m;

    typedef struct {
        logic        s;
        logic        vc;
        logic [63:0] d;
        logic        blk;
        logic        ovc;
        logic        ev;
        logic [63:0] ed;
        logic [1:0]  er;
        logic        edrop;
    } vec_t;

    vec_t        tbl[13];
    logic [63:0] flits[10];

    router_input_vc_buffer #(.DATA_W(64), .NUM_VC(2), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .send      (send),
        .in_vc     (in_vc),
        .data_in   (data_in),
        .ready     (ready),
        .blocked   (blocked),
        .out_vc    (out_vc),
        .out_valid (out_valid),
        .data_out  (data_out),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        send = 1'b1;
        in_vc = 1'(VC_ODD);
        data_in = 64'hDEAD;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        send = 1'b0;
        mq0.delete();
        mq1.delete();
        exp_q.delete();
        rdy_m = 2'b11;
        drop_m = 1'b0;
        chk("reset_ready", ready, 2'b11);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_drop_err", drop_err, 0);
    endtask

    task automatic cycle(input logic s, input logic vc, input logic [63:0] d,
                         input logic blk, input logic ovc);
        logic do_pop;
        logic [63:0] h;
        do_pop = 1'b0;
        if (!blk) begin
            if (ovc == 1'b0 && mq0.size() > 0) begin
                exp_q.push_back(mq0.pop_front());
                do_pop = 1'b1;
            end else if (ovc == 1'b1 && mq1.size() > 0) begin
                exp_q.push_back(mq1.pop_front());
                do_pop = 1'b1;
            end
        end
        if (s) begin
            if (!rdy_m[vc]) drop_m = 1'b1;
            else if (vc) mq1.push_back(d);
            else mq0.push_back(d);
        end
        rdy_m[0] = !blk && (mq0.size() < 4);
        rdy_m[1] = !blk && (mq1.size() < 4);
        send = s; in_vc = vc; data_in = d; blocked = blk; out_vc = ovc;
        @(posedge clk);
        #1;
        send = 1'b0;
        blocked = 1'b0;
        chk("out_valid", out_valid, do_pop);
        if (do_pop) begin
            h = exp_q.pop_front();
            chk("data_out", data_out, h);
        end else begin
            chk("data_out_idle", data_out, 0);
        end
        chk("ready", ready, rdy_m);
        chk("drop_err", drop_err, drop_m);
    endtask

    initial begin
        // Single flit round trip, then VC1 fill, overflow drop and ordered drain.
        tbl[0]  = '{1'b1, 1'b0, 64'hA,  1'b0, 1'b0, 1'b0, 64'h0,  2'b11, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 64'hA,  2'b11, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 64'h0,  2'b11, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 64'h0,  2'b11, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 64'h12, 1'b0, 1'b0, 1'b0, 64'h0,  2'b11, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 64'h13, 1'b0, 1'b0, 1'b0, 64'h0,  2'b11, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 64'h14, 1'b0, 1'b0, 1'b0, 64'h0,  2'b01, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 64'h15, 1'b0, 1'b0, 1'b0, 64'h0,  2'b01, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'h11, 2'b11, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'h12, 2'b11, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'h13, 2'b11, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'h14, 2'b11, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  2'b11, 1'b1};

        do_reset(2);

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].s, tbl[i].vc, tbl[i].d, tbl[i].blk, tbl[i].ovc);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_data", i), data_out, tbl[i].ed);
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].er);
            chk($sformatf("tbl%0d_drop", i), drop_err, tbl[i].edrop);
        end

        // Blocked stall with two flits waiting in VC0.
        do_reset(1);
        cycle(1'b1, 1'(VC_EVEN), 64'h21, 1'b0, 1'(VC_ODD));
        cycle(1'b1, 1'(VC_EVEN), 64'h22, 1'b0, 1'(VC_ODD));
        cycle(1'b0, 1'(VC_EVEN), 64'h0, 1'b1, 1'(VC_EVEN));
        chk("blocked_no_pop", out_valid, 0);
        chk("blocked_ready", ready, 2'b00);
        cycle(1'b0, 1'(VC_EVEN), 64'h0, 1'b0, 1'(VC_EVEN));
        chk("resume_pop", data_out, 64'h21);
        chk("resume_ready", ready, 2'b11);
        cycle(1'b0, 1'(VC_EVEN), 64'h0, 1'b0, 1'(VC_EVEN));

        // Interleaved push+pop on VC0 at steady count 2, wrapping the pointers.
        for (int i = 0; i < 10; i++)
            flits[i] = (i == 3) ? 64'h0 : {$urandom(), $urandom()};
        cycle(1'b1, 1'b0, flits[0], 1'b0, 1'b1);
        cycle(1'b1, 1'b0, flits[1], 1'b0, 1'b1);
        for (int i = 2; i < 10; i++) begin
            cycle(1'b1, 1'b0, flits[i], 1'b0, 1'b0);
            chk($sformatf("wrap_order%0d", i - 2), data_out, flits[i-2]);
        end
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("wrap_last", data_out, flits[9]);

        // Mid-operation reset discards buffered VC1 flits.
        cycle(1'b1, 1'b1, 64'h31, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'h32, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'h33, 1'b0, 1'b0);
        do_reset(1);
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        chk("post_reset_empty", out_valid, 0);
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
